// File: rtl/tlc_gs_packer_if.sv
// rtl/tlc_gs_packer_if.sv - pixel input and latch output handshake bundle for tlc_gs_packer
interface tlc_gs_packer_if;
  logic         px_valid;
  logic         px_ready;
  logic [23:0]  px_rgb;
  logic         px_sof;
  logic         ctrl_req;
  logic         lat_valid;
  logic         lat_ready;
  logic [768:0] lat_data;
  logic         lat_is_ctrl;

  modport slave (
    input  px_valid, px_rgb, px_sof, ctrl_req, lat_ready,
    output px_ready, lat_valid, lat_data, lat_is_ctrl
  );

  modport master (
    output px_valid, px_rgb, px_sof, ctrl_req, lat_ready,
    input  px_ready, lat_valid, lat_data, lat_is_ctrl
  );
endinterface

// File: rtl/tlc_gs_packer.sv
// rtl/tlc_gs_packer.sv - double-banked RGB to 769-bit TLC latch packer; TLC_CTRL_INIT_EN queues a control latch at reset
module tlc_gs_packer #(
  parameter logic [6:0] DC_VAL = 7'd127,
  parameter logic [2:0] MC_R   = 3'd0,
  parameter logic [2:0] MC_G   = 3'd0,
  parameter logic [2:0] MC_B   = 3'd0,
  parameter logic [6:0] BC_R   = 7'd127,
  parameter logic [6:0] BC_G   = 7'd127,
  parameter logic [6:0] BC_B   = 7'd127,
  parameter logic [4:0] FC_VAL = 5'b11111
) (
  input logic            CLK_10M,
  input logic            Reset,
  tlc_gs_packer_if.slave bus
);

`ifdef TLC_CTRL_INIT_EN
  localparam logic PEND_INIT = 1'b1;
`else
  localparam logic PEND_INIT = 1'b0;
`endif

  logic [767:0] bank [2];
  logic [1:0]   full;
  logic [3:0]   wcnt;
  logic         wb;
  logic         rb;
  logic         pend;
  logic         lat_valid_q;
  logic         lat_is_ctrl_q;
  logic [768:0] lat_data_q;
  logic [768:0] ctrl_word;
  logic [3:0]   ch;
  logic [9:0]   base;
  logic [47:0]  px_gs;
  logic         acc;

  assign bus.px_ready    = !full[wb];
  assign bus.lat_valid   = lat_valid_q;
  assign bus.lat_is_ctrl = lat_is_ctrl_q;
  assign bus.lat_data    = lat_data_q;

  assign acc   = bus.px_valid && bus.px_ready;
  assign ch    = bus.px_sof ? 4'd0 : wcnt;
  assign base  = 10'(ch) * 10'd48;
  assign px_gs = {bus.px_rgb[7:0],   bus.px_rgb[7:0],
                  bus.px_rgb[15:8],  bus.px_rgb[15:8],
                  bus.px_rgb[23:16], bus.px_rgb[23:16]};

  always_comb begin
    ctrl_word = '0;
    for (int i = 0; i < 48; i++) begin
      ctrl_word[7*i +: 7] = DC_VAL;
    end
    ctrl_word[338:336] = MC_R;
    ctrl_word[341:339] = MC_G;
    ctrl_word[344:342] = MC_B;
    ctrl_word[351:345] = BC_R;
    ctrl_word[358:352] = BC_G;
    ctrl_word[365:359] = BC_B;
    ctrl_word[370:366] = FC_VAL;
    ctrl_word[768]     = 1'b1;
  end

  // Channel 0 wipes the whole bank so stale or discarded channels read as zero.
  always_ff @(posedge CLK_10M or posedge Reset) begin
    if (Reset) begin
      bank[0] <= '0;
      bank[1] <= '0;
    end else if (acc) begin
      if (ch == 4'd0) begin
        bank[wb] <= {720'd0, px_gs};
      end else begin
        bank[wb][base +: 48] <= px_gs;
      end
    end
  end

  always_ff @(posedge CLK_10M or posedge Reset) begin
    if (Reset) begin
      full          <= '0;
      wcnt          <= '0;
      wb            <= 1'b0;
      rb            <= 1'b0;
      pend          <= PEND_INIT;
      lat_valid_q   <= 1'b0;
      lat_is_ctrl_q <= 1'b0;
      lat_data_q    <= '0;
    end else begin
      if (lat_valid_q) begin
        if (bus.lat_ready) begin
          lat_valid_q <= 1'b0;
          if (lat_is_ctrl_q) begin
            pend <= 1'b0;
          end else begin
            full[rb] <= 1'b0;
            rb       <= ~rb;
          end
        end
      end else if (pend) begin
        lat_valid_q   <= 1'b1;
        lat_is_ctrl_q <= 1'b1;
        lat_data_q    <= ctrl_word;
      end else if (full[rb]) begin
        lat_valid_q   <= 1'b1;
        lat_is_ctrl_q <= 1'b0;
        lat_data_q    <= {1'b0, bank[rb]};
      end

      // A request landing on the control handshake edge survives the clear above.
      if (bus.ctrl_req) begin
        pend <= 1'b1;
      end

      if (acc) begin
        wcnt <= bus.px_sof ? 4'd1 : wcnt + 4'd1;
        if (ch == 4'd15) begin
          full[wb] <= 1'b1;
          wb       <= ~wb;
        end
      end
    end
  end

endmodule

// File: tb/tb_tlc_gs_packer.sv
// tb/tb_tlc_gs_packer.sv - randomized scoreboard bench for tlc_gs_packer
module tb_tlc_gs_packer;

`ifdef TLC_CTRL_INIT_EN
  localparam bit INIT_PEND = 1'b1;
`else
  localparam bit INIT_PEND = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tlc_gs_packer_if bus();

  tlc_gs_packer dut (
    .CLK_10M (clk),
    .Reset   (rst),
    .bus     (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  logic [768:0] gq [$];
  bit           kinds [$];
  int           outstanding;
  bit           ctrl_pend;
  logic [23:0]  part [16];
  int           np;
  int           acc_cnt;
  int           n_gs;

  task automatic check_eq(input string tag, input logic [768:0] got, input logic [768:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  function automatic logic [768:0] ctrl_ref();
    logic [768:0] w;
    w = '0;
    for (int i = 0; i < 48; i++) w[7*i +: 7] = 7'd127;
    w[338:336] = 3'd0;
    w[341:339] = 3'd0;
    w[344:342] = 3'd0;
    w[351:345] = 7'd127;
    w[358:352] = 7'd127;
    w[365:359] = 7'd127;
    w[370:366] = 5'b11111;
    w[768]     = 1'b1;
    return w;
  endfunction

  function automatic logic [15:0] ex(input logic [7:0] c);
    return {c, c};
  endfunction

  task automatic model_pixel(input logic [23:0] rgb, input logic sof);
    logic [768:0] w;
    if (sof) np = 0;
    part[np] = rgb;
    np++;
    if (np == 16) begin
      w = '0;
      for (int k = 0; k < 16; k++) begin
        w[48*k      +: 16] = ex(part[k][23:16]);
        w[48*k + 16 +: 16] = ex(part[k][15:8]);
        w[48*k + 32 +: 16] = ex(part[k][7:0]);
      end
      gq.push_back(w);
      outstanding++;
      np = 0;
    end
  endtask

  task automatic model_reset();
    gq.delete();
    outstanding = 0;
    np          = 0;
    ctrl_pend   = INIT_PEND;
  endtask

  task automatic tick();
    logic         acc, hs, ic, rq, sof;
    logic [768:0] d;
    logic [23:0]  rgb;
    acc = bus.px_valid && bus.px_ready;
    hs  = bus.lat_valid && bus.lat_ready;
    ic  = bus.lat_is_ctrl;
    d   = bus.lat_data;
    rq  = bus.ctrl_req;
    rgb = bus.px_rgb;
    sof = bus.px_sof;
    check_eq("px_ready", bus.px_ready, outstanding < 2);
    @(posedge clk);
    #1;
    if (hs) begin
      kinds.push_back(ic);
      if (ic) begin
        check_eq("ctrl_pending", ctrl_pend, 1);
        check_eq("ctrl_word", d, ctrl_ref());
        ctrl_pend = 0;
      end else begin
        check_eq("gs_expected", gq.size() > 0, 1);
        if (gq.size() > 0) begin
          check_eq("gs_word", d, gq.pop_front());
          outstanding--;
          n_gs++;
        end
      end
    end
    if (rq) ctrl_pend = 1;
    if (acc) begin
      model_pixel(rgb, sof);
      acc_cnt++;
    end
  endtask

  task automatic idle_inputs();
    bus.px_valid  = 0;
    bus.px_sof    = 0;
    bus.px_rgb    = '0;
    bus.ctrl_req  = 0;
    bus.lat_ready = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    idle_inputs();
    @(posedge clk);
    #1;
    check_eq("rst_px_ready", bus.px_ready, 1);
    check_eq("rst_lat_valid", bus.lat_valid, 0);
    check_eq("rst_lat_data", bus.lat_data, 0);
    check_eq("rst_lat_is_ctrl", bus.lat_is_ctrl, 0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 0;
  endtask

  task automatic wait_valid(input string tag, input int max);
    int i = 0;
    while (!bus.lat_valid && i < max) begin
      tick();
      i++;
    end
    check_eq(tag, bus.lat_valid, 1);
  endtask

  task automatic drain(input int n);
    bus.lat_ready = 1;
    repeat (n) tick();
    bus.lat_ready = 0;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, cnt;
    logic [768:0] w;
    n_gs = 0;
    acc_cnt = 0;
    idle_inputs();
    model_reset();
    do_reset();

`ifdef TLC_CTRL_INIT_EN
    wait_valid("init_ctrl_valid", 4);
    check_eq("init_is_ctrl", bus.lat_is_ctrl, 1);
    check_eq("init_bit768", bus.lat_data[768], 1);
    check_eq("init_dc0", bus.lat_data[6:0], 7'h7F);
    check_eq("init_mc_r", bus.lat_data[338:336], 3'd0);
    check_eq("init_fc", bus.lat_data[370:366], 5'b11111);
    drain(2);
`endif

    // Grayscale word contents and latency
    bus.px_valid = 1;
    bus.px_rgb   = 24'h00FF10;
    for (int i = 0; i < 16; i++) begin
      bus.px_sof = (i == 0);
      tick();
    end
    bus.px_valid = 0;
    bus.px_sof   = 0;
    check_eq("gs_lat_edge_n", bus.lat_valid, 0);
    tick();
    check_eq("gs_lat_edge_n1", bus.lat_valid, 1);
    check_eq("gs_is_ctrl", bus.lat_is_ctrl, 0);
    check_eq("gs_bit768", bus.lat_data[768], 0);
    check_eq("gs_ch0_red", bus.lat_data[15:0], 16'h0000);
    check_eq("gs_ch0_green", bus.lat_data[31:16], 16'hFFFF);
    check_eq("gs_ch0_blue", bus.lat_data[47:32], 16'h1010);
    check_eq("gs_ch15_blue", bus.lat_data[767:752], 16'h1010);
    bus.lat_ready = 1;
    tick();
    bus.lat_ready = 0;

    // Control latency and idle gap
    check_eq("gs_idle_after_hs", bus.lat_valid, 0);
    bus.ctrl_req = 1;
    tick();
    bus.ctrl_req = 0;
    check_eq("ctrl_lat_edge_n", bus.lat_valid, 0);
    tick();
    check_eq("ctrl_lat_edge_n1", bus.lat_valid, 1);
    check_eq("ctrl_is_ctrl", bus.lat_is_ctrl, 1);
    bus.lat_ready = 1;
    tick();
    bus.lat_ready = 0;
    check_eq("ctrl_idle_after_hs", bus.lat_valid, 0);

    // Backpressure: two banks fill, then release in order
    base = acc_cnt;
    bus.px_valid = 1;
    repeat (50) begin
      bus.px_rgb = 24'($urandom);
      tick();
    end
    check_eq("bp_accepted", acc_cnt - base, 32);
    check_eq("bp_px_ready_low", bus.px_ready, 0);
    bus.lat_ready = 1;
    for (int i = 0; i < 100 && (acc_cnt - base) < 40; i++) begin
      bus.px_rgb = 24'($urandom);
      tick();
    end
    bus.px_valid = 0;
    check_eq("bp_accepted_40", acc_cnt - base, 40);
    drain(40);
    check_eq("bp_drained", gq.size(), 0);

    // Mid-latch resync; leftover 8-pixel partial is also discarded
    bus.px_valid = 1;
    bus.px_rgb   = 24'h111111;
    repeat (5) tick();
    bus.px_rgb = 24'h222222;
    bus.px_sof = 1;
    tick();
    bus.px_sof = 0;
    repeat (15) tick();
    bus.px_valid = 0;
    wait_valid("resync_valid", 4);
    check_eq("resync_ch0", bus.lat_data[15:0], 16'h2222);
    cnt = 0;
    w = bus.lat_data;
    for (int f = 0; f < 48; f++) if (w[16*f +: 16] == 16'h1111) cnt++;
    check_eq("resync_no1111", cnt, 0);
    drain(6);

    // Control request under load merges into one word
    bus.px_valid = 1;
    for (int i = 0; i < 32; i++) begin
      bus.px_sof = (i == 0);
      bus.px_rgb = 24'($urandom);
      tick();
    end
    bus.px_valid = 0;
    bus.px_sof   = 0;
    wait_valid("load_valid", 4);
    kinds.delete();
    bus.ctrl_req = 1;
    tick();
    bus.ctrl_req = 0;
    tick();
    bus.ctrl_req = 1;
    tick();
    bus.ctrl_req = 0;
    check_eq("load_no_preempt", bus.lat_is_ctrl, 0);
    drain(12);
    check_eq("load_hs_count", kinds.size(), 3);
    if (kinds.size() == 3) begin
      check_eq("load_seq0_gs", kinds[0], 0);
      check_eq("load_seq1_ctrl", kinds[1], 1);
      check_eq("load_seq2_gs", kinds[2], 0);
    end

    // Reset mid-fill
    bus.px_valid = 1;
    for (int i = 0; i < 7; i++) begin
      bus.px_sof = (i == 0);
      bus.px_rgb = 24'h333333;
      tick();
    end
    do_reset();
    base = n_gs;
    bus.px_valid = 1;
    repeat (16) begin
      bus.px_rgb = 24'($urandom);
      tick();
    end
    bus.px_valid = 0;
    drain(10);
    check_eq("rst_clean_word", n_gs - base, 1);

    // Randomized traffic
    repeat (1500) begin
      bus.px_valid  = ($urandom_range(0, 3) != 0);
      bus.px_rgb    = 24'($urandom);
      bus.px_sof    = ($urandom_range(0, 31) == 0);
      bus.lat_ready = $urandom_range(0, 1) == 1;
      bus.ctrl_req  = ($urandom_range(0, 63) == 0);
      tick();
    end
    idle_inputs();
    drain(60);
    check_eq("rand_queue_empty", gq.size(), 0);
    check_eq("rand_ctrl_clear", ctrl_pend, 0);
    check_eq("rand_out_idle", bus.lat_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/tlc_gs_packer.md
# tlc_gs_packer

Upstream feeder for the TLC LED-driver serial shifter. Accepts 24-bit RGB pixels one per clock, expands each 8-bit colour to 16-bit grayscale, and packs 16 pixels into one 769-bit grayscale latch word with latch-select bit 768 = 0. Two internal banks let one latch be filled while the other waits for the shifter. On request, it also emits a 769-bit control latch word built from parameters, with latch-select bit 768 = 1.

## Interface
- `DC_VAL`, 7'd127: dot correction for all 48 channel outputs.
- `MC_R` / `MC_G` / `MC_B`, 3'd0: max-current codes.
- `BC_R` / `BC_G` / `BC_B`, 7'd127: global brightness codes.
- `FC_VAL`, 5'b11111: function control {lsdvlt, espwm, rfresh, tmgrst, dsprpt}.
- `CLK_10M` input 1: sole clock; all logic on its rising edge.
- `Reset` input 1: asynchronous, active-high reset.
- `px_valid` input 1: pixel present.
- `px_ready` output 1: pixel accepted when `px_valid && px_ready`.
- `px_rgb` input 24: {R[23:16], G[15:8], B[7:0]}.
- `px_sof` input 1: qualified by pixel acceptance; the pixel starts a new latch at channel 0.
- `ctrl_req` input 1: one-cycle pulse; queue one control latch.
- `lat_valid` output 1: `lat_data` holds a complete word.
- `lat_ready` input 1: the shifter takes the word when `lat_valid && lat_ready`.
- `lat_data` output 769: the latch word.
- `lat_is_ctrl` output 1: the current word is a control latch.

## Operation
- **Pixel expansion:** each 8-bit colour c maps to {c, c}, so 8'hFF → 16'hFFFF and 8'h00 → 16'h0000.
- **Grayscale placement:** the pixel with channel index k (0..15) writes three fields:
  - red at [48k+15 : 48k]
  - green at [48k+31 : 48k+16]
  - blue at [48k+47 : 48k+32]
  - Bit 768 is 0.
- **Write side:**
  - A 4-bit channel counter `wcnt` and a write-bank pointer `wb` are maintained.
  - On pixel acceptance without `px_sof`, the pixel goes to channel `wcnt` and `wcnt` increments.
  - On pixel acceptance with `px_sof`, the pixel goes to channel 0, `wcnt` becomes 1, and any partial contents are discarded. Unwritten channels are read as 0.
  - When channel 15 is written, bank `wb` is marked full, `wb` toggles and `wcnt` wraps to 0.
- **Backpressure:** `px_ready` = !full[wb]. With both banks full, `px_ready` = 0.
- **Read side:** read-bank pointer `rb`.
- **Output arbiter**, evaluated whenever no word is being presented:
  - If a control latch is pending, present it with `lat_is_ctrl` = 1.
  - Otherwise, if full[rb] is set, present bank `rb`.
  - Once presented, `lat_valid` and `lat_data` stay stable until the handshake completes. A newly arriving `ctrl_req` does not pre-empt a word already being presented.
- **Handshake completion:**
  - Grayscale word: clears full[rb] and toggles `rb`.
  - Control word: clears the pending flag.
- **Control word layout:**
  - Bit 768 = 1.
  - `DC_VAL` in every 7-bit slot [7i+6 : 7i], for i = 0..47.
  - MC_R at [338:336], MC_G at [341:339], MC_B at [344:342].
  - BC_R at [351:345], BC_G at [358:352], BC_B at [365:359].
  - FC_VAL at [370:366].
  - All other bits are 0.
- **`ctrl_req`:**
  - Sets the pending flag.
  - A request arriving while one is already pending merges with it, producing one word.
- **Simultaneous events:**
  - Pixel write to bank `wb` and read handshake on bank `rb` may occur in the same cycle.
  - The full-flag clear takes effect for `px_ready` on the next cycle.

## Timing
- **Reset values:**
  - `px_ready` = 1
  - `lat_valid` = 0
  - `lat_data` = 0
  - `lat_is_ctrl` = 0
  - Both banks cleared, `wcnt` = 0, `wb` = `rb` = 0, pending = 0 except as set by the macro (see Configuration).
  - Reset mid-operation discards all buffered data immediately.
- **Pixel-to-output latency:** the 16th pixel is accepted at edge N; `lat_valid` = 1 after edge N+1, with `lat_data` registered.
- **Control latency:** `ctrl_req` sampled at edge N with the output idle → control word valid after edge N+1.
- **Back-to-back output:** after a handshake at edge N, the next queued word is valid after edge N+1, so one idle cycle follows each word.
- **Throughput:** 1 pixel per cycle sustained while a bank is free.

## Configuration
- `TLC_CTRL_INIT_EN`:
  - **Defined:** reset sets the pending flag, so the first word after reset is the control latch, ahead of any grayscale word.
  - **Undefined:** pending resets to 0, and control latches are produced only via `ctrl_req`.

## Test plan
- **Control word contents:** with the macro defined and `lat_ready` = 1 after reset, the first word has `lat_is_ctrl` = 1, bit 768 = 1, [6:0] = 7'h7F, [338:336] = 0, [370:366] = 5'b11111.
- **Grayscale word contents:**
  - Stimulus: 16 pixels with `px_rgb` = 24'h00FF10, `px_sof` on the first.
  - Every channel has green = 16'hFFFF, blue = 16'h1010, red = 0.
  - Bit 768 = 0, and `lat_valid` rises one cycle after the 16th pixel.
- **Backpressure:** with `lat_ready` = 0, stream 40 pixels. `px_ready` drops after pixel 32. Raising `lat_ready` releases bank 0 first, then bank 1, in order.
- **Mid-latch resynchronisation:** 5 pixels of 24'h111111, then `px_sof` with 24'h222222 followed by 15 more. The output has channel 0 = 16'h2222 and no 16'h1111 anywhere.
- **Control request under load:** with `lat_valid` held on a grayscale word, pulse `ctrl_req` twice. After the grayscale handshake exactly one control word follows, then the next grayscale word.
- **Reset mid-fill:** assert `Reset` after 7 pixels. All outputs return to reset values, and the next 16 pixels form a clean word.
